// File: rtl/session_timeout_ctrl.sv
// Session watchdog: 1-second tick prescaler plus per-session countdown (IDLE/RUN/WARN/EXPIRED).
// Optional SESSION_PAUSE_EN adds a pause input that freezes the countdown while busy.
module session_timeout_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 30,
  parameter int WARN_S    = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] load_s,
  input  logic             kick,
  input  logic             stop,
`ifdef SESSION_PAUSE_EN
  input  logic             pause,
`endif
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             warn,
  output logic             expired,
  output logic             timeout_p,
  output logic             sec_tick,
  output logic [1:0]       state_dbg
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_S);
  localparam logic [CNT_W-1:0] WARN_V    = CNT_W'(WARN_S);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WARN    = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             tp_q, tp_d;
  logic             st_q, st_d;

  logic             busy_w;
  logic             run_en;
  logic [CNT_W-1:0] start_val;
  logic [CNT_W-1:0] rem_dec;

`ifdef SESSION_PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  assign busy_w    = (state_q == S_RUN) || (state_q == S_WARN);
  assign start_val = (load_s == '0) ? TIMEOUT_V : load_s;
  // Saturating decrement: remaining never wraps below zero.
  assign rem_dec   = (rem_q == '0) ? '0 : rem_q - CNT_W'(1);

  function automatic state_t eval_state(input logic [CNT_W-1:0] v);
    return (v <= WARN_V) ? S_WARN : S_RUN;
  endfunction

  // Event priority: stop > start > kick > tick; lower events in the same cycle are dropped.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    tp_d     = 1'b0;
    st_d     = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      rem_d   = '0;
      presc_d = '0;
    end else if (start) begin
      reload_d = start_val;
      rem_d    = start_val;
      state_d  = eval_state(start_val);
      presc_d  = '0;
    end else if (kick && busy_w) begin
      rem_d   = reload_q;
      state_d = eval_state(reload_q);
      presc_d = '0;
    end else if (busy_w) begin
      if (run_en) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          st_d    = 1'b1;
          if (rem_dec == '0) begin
            state_d = S_EXPIRED;
            rem_d   = '0;
            tp_d    = 1'b1;
          end else begin
            rem_d   = rem_dec;
            state_d = eval_state(rem_dec);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end else begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      rem_q    <= '0;
      reload_q <= '0;
      tp_q     <= 1'b0;
      st_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      reload_q <= reload_d;
      tp_q     <= tp_d;
      st_q     <= st_d;
    end
  end

  assign remaining = rem_q;
  assign busy      = busy_w;
  assign warn      = (state_q == S_WARN);
  assign expired   = (state_q == S_EXPIRED);
  assign timeout_p = tp_q;
  assign sec_tick  = st_q;
  assign state_dbg = state_q;

endmodule
